// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional second (skid) entry that breaks the ready path between the two sides.
module pipe_stage_buffer #(
    parameter int unsigned      WIDTH       = 32,
    parameter bit               SKID        = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_BOTH  = 2'd2
    } state_e;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] main_nxt_s;
    logic [WIDTH-1:0] skid_nxt_s;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [1:0]       occupancy_r;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Upstream acceptance: registered with a skid entry, otherwise pass-through of out_ready
    always_comb begin
        in_ready_s = 1'b0;
        if (reset || flush) begin
            in_ready_s = 1'b0;
        end else if (SKID) begin
            in_ready_s = in_ready_r;
        end else begin
            in_ready_s = !out_valid_r || out_ready;
        end
    end

    assign in_xfer_s  = in_valid && in_ready_s;
    assign out_xfer_s = out_valid_r && out_ready;

    // Next-state and entry update selection
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            // Entries keep their contents; only the occupancy is discarded.
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_nxt_s = in_data;
                    end else if (out_xfer_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else if (in_xfer_s && SKID) begin
                        state_nxt_s = ST_BOTH;
                        skid_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_BOTH: begin
                    if (out_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        main_nxt_s  = skid_r;
                    end else begin
                        state_nxt_s = ST_BOTH;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, entries and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            main_r      <= RESET_VALUE;
            skid_r      <= RESET_VALUE;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            occupancy_r <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_BOTH);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed and random checks of pipe_stage_buffer with and without the skid
// entry, both instances driven by the same upstream/downstream stimulus.
module tb_pipe_stage_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        in_ready1;
    logic        out_valid1;
    logic [31:0] out_data1;
    logic [1:0]  occ1;
    logic        in_ready0;
    logic        out_valid0;
    logic [31:0] out_data0;
    logic [1:0]  occ0;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    bit model_on   = 1'b0;

    logic [31:0] q1[$];
    logic [31:0] q0[$];

    pipe_stage_buffer #(.WIDTH(32), .SKID(1'b1)) dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_buffer #(.WIDTH(32), .SKID(1'b0)) dut_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready(input int sz, input bit skid);
        if (reset || flush) return 1'b0;
        if (skid) return (sz != 2);
        return (sz == 0) || out_ready;
    endfunction

    task automatic model_check();
        if (model_on) begin
            check_value("m1_in_ready",  {31'd0, in_ready1},  {31'd0, exp_ready(q1.size(), 1'b1)});
            check_value("m1_out_valid", {31'd0, out_valid1}, {31'd0, q1.size() > 0});
            check_value("m1_occupancy", {30'd0, occ1},       q1.size());
            if (q1.size() > 0) check_value("m1_out_data", out_data1, q1[0]);
            check_value("m0_in_ready",  {31'd0, in_ready0},  {31'd0, exp_ready(q0.size(), 1'b0)});
            check_value("m0_out_valid", {31'd0, out_valid0}, {31'd0, q0.size() > 0});
            check_value("m0_occupancy", {30'd0, occ0},       q0.size());
            if (q0.size() > 0) check_value("m0_out_data", out_data0, q0[0]);
        end
    endtask

    task automatic model_update();
        logic ir1;
        logic ir0;
        logic o1;
        logic o0;
        ir1 = exp_ready(q1.size(), 1'b1);
        ir0 = exp_ready(q0.size(), 1'b0);
        o1  = (q1.size() > 0) && out_ready;
        o0  = (q0.size() > 0) && out_ready;
        if (reset || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (o1) void'(q1.pop_front());
            if (in_valid && ir1) q1.push_back(in_data);
            if (o0) void'(q0.pop_front());
            if (in_valid && ir0) q0.push_back(in_data);
        end
    endtask

    // Inputs are stable here; check, advance the model, then cross one rising edge.
    task automatic step();
        #1;
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h0000_DEAD;

        // Reset held two cycles with a pending input
        step();
        model_on = 1'b1;
        step();
        check_value("rst_in_ready1",  {31'd0, in_ready1},  32'd0);
        check_value("rst_in_ready0",  {31'd0, in_ready0},  32'd0);
        check_value("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        check_value("rst_occ1",       {30'd0, occ1},       32'd0);
        check_value("rst_out_data1",  out_data1,           32'd0);
        check_value("rst_out_data0",  out_data0,           32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check_value("post_rst_in_ready1", {31'd0, in_ready1}, 32'd1);

        // Streaming with downstream always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        check_value("stream_d0",  out_data1,           32'h11);
        check_value("stream_v0",  {31'd0, out_valid1}, 32'd1);
        check_value("stream_nd0", out_data0,           32'h11);
        in_data = 32'h22;
        step();
        check_value("stream_d1",  out_data1,          32'h22);
        check_value("stream_r1",  {31'd0, in_ready1}, 32'd1);
        check_value("stream_nd1", out_data0,          32'h22);
        in_data = 32'h33;
        step();
        check_value("stream_d2",  out_data1,          32'h33);
        check_value("stream_r2",  {31'd0, in_ready0}, 32'd1);
        in_valid = 1'b0;
        step();
        check_value("stream_drain", {31'd0, out_valid1}, 32'd0);

        // Skid fill under stall, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_data = 32'hC;
        step();
        check_value("skid_occ",     {30'd0, occ1},      32'd2);
        check_value("skid_ready",   {31'd0, in_ready1}, 32'd0);
        check_value("skid_head",    out_data1,          32'hA);
        out_ready = 1'b1;
        step();
        check_value("skid_out_b",   out_data1,           32'hB);
        check_value("skid_valid_b", {31'd0, out_valid1}, 32'd1);
        step();
        check_value("skid_out_c",   out_data1,           32'hC);
        in_valid = 1'b0;
        step();
        check_value("skid_empty",   {31'd0, out_valid1}, 32'd0);

        // Combinational ready without a skid entry
        step();
        step();
        in_valid  = 1'b1;
        in_data   = 32'h5;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        check_value("noskid_valid",    {31'd0, out_valid0}, 32'd1);
        check_value("noskid_data",     out_data0,           32'h5);
        check_value("noskid_stall_rd", {31'd0, in_ready0},  32'd0);
        out_ready = 1'b1;
        #1;
        check_value("noskid_go_rd",    {31'd0, in_ready0},  32'd1);
        step();
        check_value("noskid_consumed", {31'd0, out_valid0}, 32'd0);

        // Flush with both entries held and an input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        step();
        in_data = 32'h2;
        step();
        check_value("flush_pre_occ", {30'd0, occ1}, 32'd2);
        in_data = 32'h3;
        flush   = 1'b1;
        #1;
        check_value("flush_rd1", {31'd0, in_ready1}, 32'd0);
        check_value("flush_rd0", {31'd0, in_ready0}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_value("flush_valid1", {31'd0, out_valid1}, 32'd0);
        check_value("flush_occ1",   {30'd0, occ1},       32'd0);
        check_value("flush_valid0", {31'd0, out_valid0}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_value("flush_no_ghost", {31'd0, out_valid1}, 32'd0);
        end

        // Random traffic with occasional flush and reset, tracked by the queue model
        for (int c = 0; c < 10000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            step();
        end
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
